mempool_tcdm_txn_tracker: RTL and testbench

- Per-remote-port stage between a group TCDM master port and its NoC TCDM chimney, one instance per tile per remote port.
- Bounds the number of in-flight remote requests.
- Replaces the core-side {meta_id, core_id} tag with a compact transaction ID for NoC transport.
- Restores the original tag on the returning response through a registered output stage.

---
 rtl/mempool_tcdm_txn_tracker.sv | 195 +++++++++++++++++++
 tb/tb_mempool_tcdm_txn_tracker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mempool_tcdm_txn_tracker.sv
// Remote-port transaction tracker: swaps the core {meta_id, core_id} tag for a compact txn ID and restores it on the response.
// Latency: request path 0 cycles (combinational), response path 1 cycle (single output register).
// Backpressure: requests stall while NumOutstanding are in flight; responses are held while rsp_ready_i is low.
// Optional build macro: MEMPOOL_TCDM_TRACKER_PERF_EN adds peak_outstanding_o and stall_cycles_o.
module mempool_tcdm_txn_tracker #(
  parameter int unsigned NumOutstanding = 8,
  parameter int unsigned TxnIdWidth     = $clog2(NumOutstanding),
  parameter int unsigned MetaIdWidth    = 4,
  parameter int unsigned CoreIdWidth    = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AmoWidth       = 4,
  parameter int unsigned AddrWidth      = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  // upstream request (group master port)
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [MetaIdWidth-1:0]   req_meta_id_i,
  input  logic [CoreIdWidth-1:0]   req_core_id_i,
  input  logic                     req_wen_i,
  input  logic [DataWidth/8-1:0]   req_be_i,
  input  logic [AmoWidth-1:0]      req_amo_i,
  input  logic [DataWidth-1:0]     req_data_i,
  input  logic [AddrWidth-1:0]     req_tgt_addr_i,
  // downstream request (chimney)
  output logic                     req_valid_o,
  input  logic                     req_ready_i,
  output logic [TxnIdWidth-1:0]    req_txn_id_o,
  output logic                     req_wen_o,
  output logic [DataWidth/8-1:0]   req_be_o,
  output logic [AmoWidth-1:0]      req_amo_o,
  output logic [DataWidth-1:0]     req_data_o,
  output logic [AddrWidth-1:0]     req_tgt_addr_o,
  // response from chimney
  input  logic                     rsp_valid_i,
  output logic                     rsp_ready_o,
  input  logic [TxnIdWidth-1:0]    rsp_txn_id_i,
  input  logic [AmoWidth-1:0]      rsp_amo_i,
  input  logic [DataWidth-1:0]     rsp_data_i,
  // response to group
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [MetaIdWidth-1:0]   rsp_meta_id_o,
  output logic [CoreIdWidth-1:0]   rsp_core_id_o,
  output logic [AmoWidth-1:0]      rsp_amo_o,
  output logic [DataWidth-1:0]     rsp_data_o,
  // status
  output logic [TxnIdWidth:0]      outstanding_o,
`ifdef MEMPOOL_TCDM_TRACKER_PERF_EN
  output logic [TxnIdWidth:0]      peak_outstanding_o,
  output logic [31:0]              stall_cycles_o,
`endif
  output logic                     err_unexp_rsp_o
);

  localparam int unsigned TagWidth = MetaIdWidth + CoreIdWidth;
  localparam logic [TxnIdWidth:0] CntMax = (TxnIdWidth+1)'(NumOutstanding);
  localparam logic [TxnIdWidth:0] CntOne = (TxnIdWidth+1)'(1);

  logic [NumOutstanding-1:0] r_busy;
  logic [TxnIdWidth:0]       r_count;
  logic [TagWidth-1:0]       r_tag_table [NumOutstanding];

  logic                      r_rsp_vld;
  logic [MetaIdWidth-1:0]    r_rsp_meta;
  logic [CoreIdWidth-1:0]    r_rsp_core;
  logic [AmoWidth-1:0]       r_rsp_amo;
  logic [DataWidth-1:0]      r_rsp_data;
  logic                      r_err;

  logic                      w_full;
  logic [TxnIdWidth-1:0]     w_free_id;
  logic                      w_alloc;
  logic                      w_rsp_hs;
  logic                      w_rsp_load;
  logic [NumOutstanding-1:0] w_alloc_mask;
  logic [NumOutstanding-1:0] w_free_mask;
  logic [TxnIdWidth:0]       w_count_nxt;
  logic [TagWidth-1:0]       w_tag_rd;

  assign w_full = (r_count == CntMax);

  // Lowest clear bit of the registered busy mask; stays put until a handshake changes the mask.
  always_comb begin
    w_free_id = '0;
    for (int i = NumOutstanding - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_id = TxnIdWidth'(i);
    end
  end

  assign req_valid_o    = req_valid_i & ~w_full;
  assign req_ready_o    = req_ready_i & ~w_full;
  assign req_txn_id_o   = w_free_id;
  assign req_wen_o      = req_wen_i;
  assign req_be_o       = req_be_i;
  assign req_amo_o      = req_amo_i;
  assign req_data_o     = req_data_i;
  assign req_tgt_addr_o = req_tgt_addr_i;

  assign w_alloc    = req_valid_i & req_ready_o;
  assign rsp_ready_o = ~r_rsp_vld | rsp_ready_i;
  assign w_rsp_hs   = rsp_valid_i & rsp_ready_o;
  // A response only counts if its ID is actually in flight; others are swallowed and flagged.
  assign w_rsp_load = w_rsp_hs & r_busy[rsp_txn_id_i];
  assign w_tag_rd   = r_tag_table[rsp_txn_id_i];

  // One-hot set/clear masks; the allocated ID is free and the freed ID is busy, so they never collide.
  always_comb begin
    w_alloc_mask = '0;
    w_free_mask  = '0;
    if (w_alloc)    w_alloc_mask[w_free_id]    = 1'b1;
    if (w_rsp_load) w_free_mask[rsp_txn_id_i]  = 1'b1;
  end

  // Next in-flight count; allocate and free in the same cycle cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (w_alloc && !w_rsp_load)      w_count_nxt = r_count + CntOne;
    else if (!w_alloc && w_rsp_load) w_count_nxt = r_count - CntOne;
  end

  // Busy mask and in-flight counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= (r_busy | w_alloc_mask) & ~w_free_mask;
      r_count <= w_count_nxt;
    end
  end

  // Tag table: remember the core tag under the granted ID.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumOutstanding; i++) r_tag_table[i] <= '0;
    end else if (w_alloc) begin
      r_tag_table[w_free_id] <= {req_meta_id_i, req_core_id_i};
    end
  end

  // Single-entry response register with restored tag; holds while the group stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_vld  <= 1'b0;
      r_rsp_meta <= '0;
      r_rsp_core <= '0;
      r_rsp_amo  <= '0;
      r_rsp_data <= '0;
    end else if (w_rsp_load) begin
      r_rsp_vld  <= 1'b1;
      r_rsp_meta <= w_tag_rd[TagWidth-1:CoreIdWidth];
      r_rsp_core <= w_tag_rd[CoreIdWidth-1:0];
      r_rsp_amo  <= rsp_amo_i;
      r_rsp_data <= rsp_data_i;
    end else if (rsp_ready_i) begin
      r_rsp_vld  <= 1'b0;
    end
  end

  // Error pulse one cycle after a response to an ID that was not in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_err <= 1'b0;
    else         r_err <= w_rsp_hs & ~r_busy[rsp_txn_id_i];
  end

  assign rsp_valid_o     = r_rsp_vld;
  assign rsp_meta_id_o   = r_rsp_meta;
  assign rsp_core_id_o   = r_rsp_core;
  assign rsp_amo_o       = r_rsp_amo;
  assign rsp_data_o      = r_rsp_data;
  assign outstanding_o   = r_count;
  assign err_unexp_rsp_o = r_err;

`ifdef MEMPOOL_TCDM_TRACKER_PERF_EN
  logic [TxnIdWidth:0] r_peak;
  logic [31:0]         r_stall;

  // High-water mark of the in-flight count and stalled-request cycle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_peak  <= '0;
      r_stall <= '0;
    end else begin
      if (w_count_nxt > r_peak)   r_peak  <= w_count_nxt;
      if (req_valid_i && w_full)  r_stall <= r_stall + 32'd1;
    end
  end

  assign peak_outstanding_o = r_peak;
  assign stall_cycles_o     = r_stall;
`endif

endmodule

// File: tb/tb_mempool_tcdm_txn_tracker.sv
// Randomized + directed bench for mempool_tcdm_txn_tracker with a scoreboard on the response path.
// Driver drives 1 time unit after posedge and updates the reference model at negedge.
// Monitor pops the expected-response queue on every rsp_valid_o & rsp_ready_i.
module tb_mempool_tcdm_txn_tracker;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_wen_i, req_valid_o, req_ready_i;
  logic [3:0]  req_meta_id_i, req_be_i, req_amo_i;
  logic [1:0]  req_core_id_i;
  logic [31:0] req_data_i, req_tgt_addr_i;
  logic [2:0]  req_txn_id_o;
  logic        req_wen_o;
  logic [3:0]  req_be_o, req_amo_o;
  logic [31:0] req_data_o, req_tgt_addr_o;
  logic        rsp_valid_i, rsp_ready_o, rsp_valid_o, rsp_ready_i;
  logic [2:0]  rsp_txn_id_i;
  logic [3:0]  rsp_amo_i, rsp_meta_id_o, rsp_amo_o;
  logic [31:0] rsp_data_i, rsp_data_o;
  logic [1:0]  rsp_core_id_o;
  logic [3:0]  outstanding_o;
  logic        err_unexp_rsp_o;
`ifdef MEMPOOL_TCDM_TRACKER_PERF_EN
  logic [3:0]  peak_outstanding_o;
  logic [31:0] stall_cycles_o;
`endif

  mempool_tcdm_txn_tracker dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_meta_id_i(req_meta_id_i), .req_core_id_i(req_core_id_i),
    .req_wen_i(req_wen_i), .req_be_i(req_be_i), .req_amo_i(req_amo_i),
    .req_data_i(req_data_i), .req_tgt_addr_i(req_tgt_addr_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_txn_id_o(req_txn_id_o),
    .req_wen_o(req_wen_o), .req_be_o(req_be_o), .req_amo_o(req_amo_o),
    .req_data_o(req_data_o), .req_tgt_addr_o(req_tgt_addr_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_txn_id_i(rsp_txn_id_i),
    .rsp_amo_i(rsp_amo_i), .rsp_data_i(rsp_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_meta_id_o(rsp_meta_id_o), .rsp_core_id_o(rsp_core_id_o),
    .rsp_amo_o(rsp_amo_o), .rsp_data_o(rsp_data_o),
    .outstanding_o(outstanding_o),
`ifdef MEMPOOL_TCDM_TRACKER_PERF_EN
    .peak_outstanding_o(peak_outstanding_o), .stall_cycles_o(stall_cycles_o),
`endif
    .err_unexp_rsp_o(err_unexp_rsp_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0]  meta;
    logic [1:0]  core;
    logic [3:0]  amo;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  // Reference model: which IDs are in flight and what tag each carries.
  bit          m_busy [N];
  logic [5:0]  m_tag  [N];
  bit          m_out_vld;
  bit          m_err_exp;
  int          m_peak;
  int unsigned m_stall;
  logic [2:0]  last_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_busy[i] ? 1 : 0;
    return c;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_tag[i] = '0; end
    m_out_vld = 0; m_err_exp = 0; m_peak = 0; m_stall = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive, then check against the model and advance the model.
  task automatic step(input bit rv, input bit drdy, input logic [3:0] meta, input logic [1:0] core,
                      input bit sv, input logic [2:0] sid, input logic [31:0] sdata, input bit srdy);
    int  cnt, low;
    bit  full, alloc, rsp_hs, loaded;
    @(posedge clk); #1;
    req_valid_i = rv; req_ready_i = drdy; req_meta_id_i = meta; req_core_id_i = core;
    req_wen_i = 1'($urandom); req_be_i = 4'($urandom); req_amo_i = 4'($urandom);
    req_data_i = $urandom; req_tgt_addr_i = $urandom;
    rsp_valid_i = sv; rsp_txn_id_i = sid; rsp_data_i = sdata; rsp_amo_i = 4'($urandom);
    rsp_ready_i = srdy;
    @(negedge clk);
    cnt = m_count(); full = (cnt == N); low = m_lowest();
    chk("req_valid_o", 64'(req_valid_o), 64'(rv && !full));
    chk("req_ready_o", 64'(req_ready_o), 64'(drdy && !full));
    if (!full) chk("req_txn_id_o", 64'(req_txn_id_o), 64'(low));
    chk("outstanding_o", 64'(outstanding_o), 64'(cnt));
    chk("req_fwd_ctl", {req_wen_o, req_be_o, req_amo_o}, {req_wen_i, req_be_i, req_amo_i});
    chk("req_fwd_dat", {req_data_o, req_tgt_addr_o}, {req_data_i, req_tgt_addr_i});
    chk("rsp_valid_o", 64'(rsp_valid_o), 64'(m_out_vld));
    chk("rsp_ready_o", 64'(rsp_ready_o), 64'(!m_out_vld || srdy));
    chk("err_unexp_rsp_o", 64'(err_unexp_rsp_o), 64'(m_err_exp));
`ifdef MEMPOOL_TCDM_TRACKER_PERF_EN
    chk("peak_outstanding_o", 64'(peak_outstanding_o), 64'(m_peak));
    chk("stall_cycles_o", 64'(stall_cycles_o), 64'(m_stall));
`endif
    last_id = req_txn_id_o;
    // advance model to the state after the coming posedge
    alloc  = rv && drdy && !full;
    rsp_hs = sv && (!m_out_vld || srdy);
    loaded = 0;
    m_err_exp = 0;
    if (rsp_hs) begin
      if (m_busy[sid]) begin
        exp_q.push_back({m_tag[sid][5:2], m_tag[sid][1:0], rsp_amo_i, sdata});
        m_busy[sid] = 0;
        loaded = 1;
      end else begin
        m_err_exp = 1;
      end
    end
    if (alloc) begin
      m_busy[low] = 1;
      m_tag[low]  = {meta, core};
    end
    if (loaded)    m_out_vld = 1;
    else if (srdy) m_out_vld = 0;
    if (rv && full) m_stall++;
    if (m_count() > m_peak) m_peak = m_count();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 4'h0, 2'h0, 0, 3'h0, 32'h0, 1);
  endtask

  // Respond to every in-flight ID (lowest first), bounded.
  task automatic drain();
    for (int i = 0; i < 40 && m_count() > 0; i++) begin
      int id = 0;
      for (int k = N - 1; k >= 0; k--) if (m_busy[k]) id = k;
      step(0, 1, 4'h0, 2'h0, 1, 3'(id), $urandom, 1);
    end
    idle(2);
  endtask

  // Scoreboard monitor: every delivered response must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rsp_unexpected_output: got meta=%0h data=0x%0h expected no response", rsp_meta_id_o, rsp_data_o);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_payload", 64'({rsp_meta_id_o, rsp_core_id_o, rsp_amo_o, rsp_data_o}), 64'(e));
      end
    end
  end

  initial begin
    logic [2:0] ids [4];
    ids[0] = 3'd2; ids[1] = 3'd0; ids[2] = 3'd3; ids[3] = 3'd1;
    rst_n = 1'b0;
    req_valid_i = 0; req_ready_i = 0; req_meta_id_i = 0; req_core_id_i = 0; req_wen_i = 0;
    req_be_i = 0; req_amo_i = 0; req_data_i = 0; req_tgt_addr_i = 0;
    rsp_valid_i = 0; rsp_txn_id_i = 0; rsp_amo_i = 0; rsp_data_i = 0; rsp_ready_i = 0;
    model_reset();
    #12;
    chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("reset_outstanding", 64'(outstanding_o), 64'd0);
    chk("reset_req_valid", 64'(req_valid_o), 64'd0);
    chk("reset_err", 64'(err_unexp_rsp_o), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // single read
    step(1, 1, 4'd3, 2'd1, 0, 3'd0, 32'h0, 1);
    chk("single_grant_id", 64'(last_id), 64'd0);
    step(0, 1, 4'd0, 2'd0, 1, 3'd0, 32'hDEADBEEF, 1);
    idle(2);

    // fill, stall at full, free + reuse
    for (int i = 0; i < N; i++) step(1, 1, 4'(i), 2'(i), 0, 3'd0, 32'h0, 1);
    step(1, 1, 4'hA, 2'd2, 0, 3'd0, 32'h0, 1);
    chk("fill_outstanding", 64'(outstanding_o), 64'd8);
    step(1, 1, 4'hA, 2'd2, 1, 3'd5, 32'h5555_0005, 1);
    step(1, 1, 4'hA, 2'd2, 0, 3'd0, 32'h0, 1);
    chk("fill_reuse_id", 64'(last_id), 64'd5);
    drain();

    // out-of-order return
    for (int i = 0; i < 4; i++) step(1, 1, 4'(i + 8), 2'(3 - i), 0, 3'd0, 32'h0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 4'h0, 2'h0, 1, ids[i], 32'h1000 + 32'(i), 1);
    step(1, 1, 4'hF, 2'd0, 0, 3'd0, 32'h0, 1);
    chk("ooo_next_id", 64'(last_id), 64'd0);
    drain();

    // response backpressure
    for (int i = 0; i < 4; i++) step(1, 1, 4'(i + 4), 2'(i), 0, 3'd0, 32'h0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 4'h0, 2'h0, 1, 3'd0, 32'hB0B0_0000, 0);
    for (int i = 1; i < 4; i++) step(0, 1, 4'h0, 2'h0, 1, 3'(i), 32'hB0B0_0000 + 32'(i), 1);
    drain();

    // unexpected ID while idle
    step(0, 1, 4'h0, 2'h0, 1, 3'd5, 32'h0BAD_0005, 1);
    step(0, 1, 4'h0, 2'h0, 0, 3'd0, 32'h0, 1);
    chk("unexp_err_pulse", 64'(err_unexp_rsp_o), 64'd1);
    idle(2);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int busy_ids[$];
      logic [2:0] sid;
      for (int k = 0; k < N; k++) if (m_busy[k]) busy_ids.push_back(k);
      if (busy_ids.size() > 0 && $urandom_range(0, 15) != 0)
        sid = 3'(busy_ids[$urandom_range(0, busy_ids.size() - 1)]);
      else
        sid = 3'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom),
           $urandom_range(0, 2) != 0, sid, $urandom, $urandom_range(0, 3) != 0);
    end
    drain();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // asynchronous reset with 4 in flight and a response pending
    for (int i = 0; i < 5; i++) step(1, 1, 4'(i), 2'(i), 0, 3'd0, 32'h0, 1);
    step(0, 1, 4'h0, 2'h0, 1, 3'd1, 32'hCAFE_0001, 0);
    @(posedge clk); #2;
    req_valid_i = 0; rsp_valid_i = 0;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("arst_outstanding", 64'(outstanding_o), 64'd0);
    chk("arst_req_valid", 64'(req_valid_o), 64'd0);
    chk("arst_err", 64'(err_unexp_rsp_o), 64'd0);
`ifdef MEMPOOL_TCDM_TRACKER_PERF_EN
    chk("arst_peak", 64'(peak_outstanding_o), 64'd0);
    chk("arst_stall", 64'(stall_cycles_o), 64'd0);
`endif
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    step(1, 1, 4'h7, 2'd3, 0, 3'd0, 32'h0, 1);
    chk("post_reset_id", 64'(last_id), 64'd0);
    drain();
    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
